// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - captures A/B operands and emits diagonally skewed west/north streams for a SIZExSIZE systolic array
module systolic_feeder #(
    parameter int SIZE       = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [SIZE*SIZE*DATA_WIDTH-1:0]   a_flat,
    input  logic [SIZE*SIZE*DATA_WIDTH-1:0]   b_flat,
    output logic [DATA_WIDTH-1:0]             out_west  [0:SIZE-1],
    output logic [DATA_WIDTH-1:0]             out_north [0:SIZE-1],
    output logic                              array_clr,
    output logic                              busy,
    output logic                              done
);

    localparam int TW = $clog2(3*SIZE);
    localparam logic [TW-1:0] FEED_LAST  = TW'(3*SIZE-3);
    localparam logic [TW-1:0] DRAIN_LAST = TW'(SIZE-1);

    typedef enum logic [2:0] {IDLE, CLR, FEED, DRAIN, DONE} state_t;

    state_t                            state;
    logic [TW-1:0]                     t;
    logic [SIZE*SIZE*DATA_WIDTH-1:0]   a_q;
    logic [SIZE*SIZE*DATA_WIDTH-1:0]   b_q;

    logic                              feed_next;
    int                                step;
    logic [DATA_WIDTH-1:0]             west_nxt  [0:SIZE-1];
    logic [DATA_WIDTH-1:0]             north_nxt [0:SIZE-1];

    // Lanes are computed for the step the next cycle will present, so the
    // registered outputs line up with the FEED step counter.
    always_comb begin
        feed_next = (state == CLR) || ((state == FEED) && (t != FEED_LAST));
        step      = (state == CLR) ? 0 : int'(t) + 1;
        for (int i = 0; i < SIZE; i++) begin
            west_nxt[i]  = '0;
            north_nxt[i] = '0;
            if (feed_next && (step >= i) && (step - i < SIZE)) begin
                west_nxt[i]  = a_q[(i*SIZE + (step - i))*DATA_WIDTH +: DATA_WIDTH];
                north_nxt[i] = b_q[((step - i)*SIZE + i)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            t         <= '0;
            a_q       <= '0;
            b_q       <= '0;
            array_clr <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            for (int i = 0; i < SIZE; i++) begin
                out_west[i]  <= '0;
                out_north[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SIZE; i++) begin
                out_west[i]  <= west_nxt[i];
                out_north[i] <= north_nxt[i];
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= CLR;
                        a_q       <= a_flat;
                        b_q       <= b_flat;
                        array_clr <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                CLR: begin
                    state     <= FEED;
                    t         <= '0;
                    array_clr <= 1'b0;
                end
                FEED: begin
                    if (t == FEED_LAST) begin
                        state <= DRAIN;
                        t     <= '0;
                    end else begin
                        t <= t + 1'b1;
                    end
                end
                DRAIN: begin
                    if (t == DRAIN_LAST) begin
                        state <= DONE;
                        t     <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        t <= t + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    t         <= '0;
                    array_clr <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// tb/tb_systolic_feeder.sv - randomized self-checking bench for systolic_feeder against a cycle-indexed skew model
module tb_systolic_feeder;

    localparam int S  = 4;
    localparam int DW = 32;
    localparam int P  = 4*S + 1;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [S*S*DW-1:0]     a_flat;
    logic [S*S*DW-1:0]     b_flat;
    logic [DW-1:0]         out_west  [0:S-1];
    logic [DW-1:0]         out_north [0:S-1];
    logic                  array_clr;
    logic                  busy;
    logic                  done;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] ma [S][S];
    logic [DW-1:0] mb [S][S];

    systolic_feeder #(.SIZE(S), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a_flat    (a_flat),
        .b_flat    (b_flat),
        .out_west  (out_west),
        .out_north (out_north),
        .array_clr (array_clr),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pack_ops();
        for (int r = 0; r < S; r++)
            for (int c = 0; c < S; c++) begin
                a_flat[(r*S+c)*DW +: DW] = ma[r][c];
                b_flat[(r*S+c)*DW +: DW] = mb[r][c];
            end
    endtask

    task automatic rand_ops();
        for (int r = 0; r < S; r++)
            for (int c = 0; c < S; c++) begin
                ma[r][c] = $urandom;
                mb[r][c] = $urandom;
            end
        pack_ops();
    endtask

    // rel = cycles since the start-sampling edge; 0 or out of 1..4S means idle.
    function automatic logic [DW-1:0] lane_exp(input int rel, input int lane, input bit west);
        int d;
        d = rel - 2 - lane;
        if (rel < 1 || rel > 4*S || d < 0 || d >= S) return '0;
        return west ? ma[lane][d] : mb[d][lane];
    endfunction

    task automatic check_cycle(input int rel, input string ctx);
        check($sformatf("%s c%0d array_clr", ctx, rel), DW'(array_clr), DW'(rel == 1));
        check($sformatf("%s c%0d busy", ctx, rel), DW'(busy), DW'(rel >= 1 && rel <= 4*S-1));
        check($sformatf("%s c%0d done", ctx, rel), DW'(done), DW'(rel == 4*S));
        for (int i = 0; i < S; i++) begin
            check($sformatf("%s c%0d west%0d", ctx, rel, i), out_west[i], lane_exp(rel, i, 1'b1));
            check($sformatf("%s c%0d north%0d", ctx, rel, i), out_north[i], lane_exp(rel, i, 1'b0));
        end
    endtask

    task automatic run_single(input string ctx);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 4*S + 3; c++) begin
            check_cycle(c, ctx);
            tick();
        end
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        rand_ops();

        for (int k = 0; k < 4; k++) begin
            start = 1'($urandom);
            rand_ops();
            tick();
            check_cycle(0, "reset");
        end
        rst   = 1'b1;
        start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            check_cycle(0, "idle");
        end

        for (int r = 0; r < S; r++)
            for (int c = 0; c < S; c++) begin
                ma[r][c] = DW'(16*r + c + 1);
                mb[r][c] = DW'(16*r + c + 'h81);
            end
        pack_ops();
        run_single("skew");

        for (int k = 0; k < 4; k++) begin
            rand_ops();
            run_single($sformatf("rand%0d", k));
        end

        rand_ops();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 4*S + 4; c++) begin
            check_cycle(c, "isolate");
            if (c == 3) begin
                a_flat = ~a_flat;
                b_flat = ~b_flat;
            end
            start = (c == 5);
            tick();
        end
        start = 1'b0;
        pack_ops();

        rand_ops();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 7; c++) begin
            check_cycle(c, "abort_pre");
            tick();
        end
        check_cycle(7, "abort_pre");
        rst = 1'b0;
        #1;
        check_cycle(0, "abort_now");
        tick();
        tick();
        rst = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            check_cycle(0, "abort_after");
        end

        rand_ops();
        start = 1'b1;
        for (int c = 1; c <= 2*P + 2; c++) begin
            int rel;
            tick();
            rel = ((c - 1) % P) + 1;
            check_cycle((rel == P) ? 0 : rel, "b2b");
        end
        start = 1'b0;
        for (int k = 0; k < 4*S + 2; k++) tick();
        check_cycle(0, "b2b_end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
